// File: rtl/imm_gen_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// imm_gen_stage
//
// Registered immediate-generation stage between fetch and execute. Each
// accepted {instr, pc} pair is decoded into an immediate format and a
// sign-extended immediate. The stage also computes the branch/jump target
// pc + imm. The result is buffered in a DEPTH-entry FIFO. The FIFO provides
// back-pressure and can be emptied by a synchronous flush.
//
// Optional feature macro: IMM_GEN_DMA_EN
//   defined   -> custom DMAW (instr[6:2]=11110) and DMAB (11101) opcodes decode
//                to type 7 with a zero-extended instr[31:20] immediate
//   undefined -> those opcodes decode as type 0 with imm = 0, and no DMA
//                decode logic is built
//
// Parameters
//   XLEN  : datapath width, 32 or 64
//   DEPTH : FIFO entries, power of two, >= 2
//
// Ports
//   clk_i            clock, all state updates on the rising edge
//   rst_n_i          asynchronous active-low reset
//   flush_i          synchronous flush, discards every buffered entry
//   in_valid_i       in_instr_i / in_pc_i valid
//   in_ready_o       stage can accept (FIFO not full)
//   in_instr_i       instruction word
//   in_pc_i          instruction address
//   out_valid_o      FIFO head valid
//   out_ready_i      consumer accepts the head entry
//   out_instr_o      head instruction
//   out_pc_o         head pc
//   out_imm_o        head immediate
//   out_imm_type_o   0 none/R, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR-zimm, 7 DMA
//   out_target_o     head pc + imm, modulo 2^XLEN
// -----------------------------------------------------------------------------
module imm_gen_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [2:0]      out_imm_type_o,
    output logic [XLEN-1:0] out_target_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;
`ifdef IMM_GEN_DMA_EN
    localparam logic [4:0] OPC_DMAB   = 5'b11101;
    localparam logic [4:0] OPC_DMAW   = 5'b11110;
`endif

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5,
        IMM_CSR  = 3'd6,
        IMM_DMA  = 3'd7
    } imm_type_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        imm_type_e       imm_type;
        logic [XLEN-1:0] target;
    } entry_t;

    // -------------------------------------------------------------------------
    // Immediate decode (combinational, ahead of the FIFO write)
    // -------------------------------------------------------------------------
    logic [4:0]      opcode;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_csr;
`ifdef IMM_GEN_DMA_EN
    logic [XLEN-1:0] imm_dma;
`endif

    assign opcode = in_instr_i[6:2];

    // Sign extension from instr[31]: a signed operand sized up to XLEN
    // replicates its MSB, which also covers U-type on a 64-bit datapath.
    assign imm_i   = XLEN'($signed(in_instr_i[31:20]));
    assign imm_s   = XLEN'($signed({in_instr_i[31:25], in_instr_i[11:7]}));
    assign imm_b   = XLEN'($signed({in_instr_i[31], in_instr_i[7],
                                    in_instr_i[30:25], in_instr_i[11:8], 1'b0}));
    assign imm_u   = XLEN'($signed({in_instr_i[31:12], 12'h000}));
    assign imm_j   = XLEN'($signed({in_instr_i[31], in_instr_i[19:12],
                                    in_instr_i[20], in_instr_i[30:21], 1'b0}));
    // CSR immediate forms carry a 5-bit unsigned zimm in the rs1 field
    assign imm_csr = XLEN'(in_instr_i[19:15]);
`ifdef IMM_GEN_DMA_EN
    assign imm_dma = XLEN'(in_instr_i[31:20]);
`endif

    imm_type_e       dec_type;
    logic [XLEN-1:0] dec_imm;
    entry_t          dec_entry;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // that no path through the case leaves it unassigned (no latch).
        dec_type = IMM_NONE;
        dec_imm  = '0;
        unique case (opcode)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                dec_type = IMM_I;
                dec_imm  = imm_i;
            end
            OPC_STORE: begin
                dec_type = IMM_S;
                dec_imm  = imm_s;
            end
            OPC_BRANCH: begin
                dec_type = IMM_B;
                dec_imm  = imm_b;
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_type = IMM_U;
                dec_imm  = imm_u;
            end
            OPC_JAL: begin
                dec_type = IMM_J;
                dec_imm  = imm_j;
            end
            OPC_SYSTEM: begin
                // funct3[2] separates the zimm CSR forms from the register
                // forms, which keep the I-type CSR address as their immediate.
                if (in_instr_i[14]) begin
                    dec_type = IMM_CSR;
                    dec_imm  = imm_csr;
                end else begin
                    dec_type = IMM_I;
                    dec_imm  = imm_i;
                end
            end
`ifdef IMM_GEN_DMA_EN
            OPC_DMAW, OPC_DMAB: begin
                dec_type = IMM_DMA;
                dec_imm  = imm_dma;
            end
`endif
            default: begin
                dec_type = IMM_NONE;
                dec_imm  = '0;
            end
        endcase
    end

    always_comb begin
        dec_entry.instr    = in_instr_i;
        dec_entry.pc       = in_pc_i;
        dec_entry.imm      = dec_imm;
        dec_entry.imm_type = dec_type;
        // Target is resolved at push time, so execute needs no adder on
        // this path. Overflow wraps modulo 2^XLEN.
        dec_entry.target   = in_pc_i + dec_imm;
    end

    // -------------------------------------------------------------------------
    // Output FIFO control
    // -------------------------------------------------------------------------
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             push;
    logic             pop;

    // Ready comes only from the registered count. This keeps out_ready_i out
    // of the in_ready_o path, so a pop into a full FIFO frees the slot one
    // cycle later.
    assign in_ready_o  = (count_q < CNT_W'(DEPTH));
    assign out_valid_o = (count_q != '0);
    assign push        = in_valid_i && in_ready_o;
    assign pop         = out_valid_o && out_ready_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            // Flush wins over any push or pop in the same cycle.
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            // DEPTH is a power of two, so the natural pointer roll-over
            // gives the modulo-DEPTH wrap.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples its pre-edge inputs, whatever the statement order.
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // FIFO storage
    // -------------------------------------------------------------------------
    entry_t mem_q [DEPTH];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the storage is reset because the outputs are driven straight
            // from it and must read zero out of reset. This stays cheap only
            // because DEPTH is small.
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush_i) begin
            mem_q[wr_ptr_q] <= dec_entry;
        end
    end

    // Outputs come from a registered slot. While the head is stalled, neither
    // the slot nor rd_ptr_q changes, so the outputs hold.
    entry_t head;

    assign head           = mem_q[rd_ptr_q];
    assign out_instr_o    = head.instr;
    assign out_pc_o       = head.pc;
    assign out_imm_o      = head.imm;
    assign out_imm_type_o = head.imm_type;
    assign out_target_o   = head.target;

endmodule
